// File: rtl/ppi_hs_ctrl.sv
// Clocked 8255-style parallel port controller: NCH channels, each mode 0 (basic I/O)
// or mode 1 (strobed handshake). Define PPI_HS_SYNC_EN to pass hs_n through a 2-flop synchroniser.

module ppi_hs_chan #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          modeSet,
  input  logic          inteWr,
  input  logic          dataWr,
  input  logic          dataRd,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] portIn,
  input  logic          hsN,
  output logic [DW-1:0] portOut,
  output logic [DW-1:0] rdData,
  output logic          portOe,
  output logic          bufFlag,
  output logic          intr
);
  logic          mode, dir, inte, intrReq;
  logic [DW-1:0] inLatch;
  logic          hsD, hsPrev, hsFall, hsRise;

`ifdef PPI_HS_SYNC_EN
  logic hsMeta, hsSync;
  always_ff @(posedge clk) begin
    if (reset) begin
      hsMeta <= 1'b1;
      hsSync <= 1'b1;
    end else begin
      hsMeta <= hsN;
      hsSync <= hsMeta;
    end
  end
  assign hsD = hsSync;
`else
  assign hsD = hsN;
`endif

  always_ff @(posedge clk) begin
    if (reset) hsPrev <= 1'b1;
    else       hsPrev <= hsD;
  end

  assign hsFall = ~hsD & hsPrev;
  assign hsRise = hsD & ~hsPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= 1'b0;
      dir     <= 1'b1;
      inte    <= 1'b0;
      intrReq <= 1'b0;
      bufFlag <= 1'b0;
      portOut <= '0;
      inLatch <= '0;
    end else if (modeSet) begin
      mode    <= din[1];
      dir     <= din[0];
      inte    <= 1'b0;
      intrReq <= 1'b0;
      bufFlag <= 1'b0;
      portOut <= '0;
    end else begin
      if (inteWr) inte <= din[0];
      if (mode && dir) begin
        // a strobe landing on the same edge as the CPU read keeps IBF set
        if (dataRd) begin
          bufFlag <= 1'b0;
          intrReq <= 1'b0;
        end
        if (hsFall) begin
          inLatch <= portIn;
          bufFlag <= 1'b1;
        end else if (hsRise && bufFlag && !dataRd) begin
          intrReq <= 1'b1;
        end
      end else if (mode) begin
        if (hsFall)                 bufFlag <= 1'b0;
        else if (hsRise && !bufFlag) intrReq <= 1'b1;
        // CPU write placed last so it wins over a coincident ACK
        if (dataWr) begin
          portOut <= din;
          bufFlag <= 1'b1;
          intrReq <= 1'b0;
        end
      end else if (!dir && dataWr) begin
        portOut <= din;
      end
    end
  end

  assign portOe = ~dir;
  assign intr   = intrReq & inte;
  assign rdData = dir ? (mode ? inLatch : portIn) : portOut;
endmodule

module ppi_hs_ctrl #(
  parameter int DW  = 8,
  parameter int NCH = 2,
  parameter int AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  input  logic [NCH*DW-1:0] port_in,
  output logic [NCH*DW-1:0] port_out,
  output logic [NCH-1:0]    port_oe,
  input  logic [NCH-1:0]    hs_n,
  output logic [NCH-1:0]    buf_flag,
  output logic [NCH-1:0]    intr
);
  localparam logic [AW-1:0] CTRL_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] STAT_ADDR = CTRL_ADDR - AW'(1);

  logic                    prevWr, prevRd;
  logic                    wrAcc, rdAcc, ctrlWr;
  logic [NCH-1:0][DW-1:0]  chRd;
  logic [DW-1:0]           rdMux;

  always_ff @(posedge clk) begin
    if (reset) begin
      prevWr <= 1'b1;
      prevRd <= 1'b1;
    end else begin
      prevWr <= wr_n;
      prevRd <= rd_n;
    end
  end

  // falling strobe edges only, so a held strobe acts once; write beats read
  assign wrAcc  = ~cs_n & ~wr_n & prevWr;
  assign rdAcc  = ~cs_n & ~rd_n & prevRd & ~wrAcc;
  assign ctrlWr = wrAcc & (addr == CTRL_ADDR);

  for (genvar i = 0; i < NCH; i++) begin : gChan
    logic selCh, selData;
    assign selCh   = (din[6:4] == 3'(i));
    assign selData = (addr == AW'(i));

    ppi_hs_chan #(.DW(DW)) uChan (
      .clk     (clk),
      .reset   (reset),
      .modeSet (ctrlWr & din[7] & selCh),
      .inteWr  (ctrlWr & ~din[7] & selCh),
      .dataWr  (wrAcc & selData),
      .dataRd  (rdAcc & selData),
      .din     (din),
      .portIn  (port_in[i*DW +: DW]),
      .hsN     (hs_n[i]),
      .portOut (port_out[i*DW +: DW]),
      .rdData  (chRd[i]),
      .portOe  (port_oe[i]),
      .bufFlag (buf_flag[i]),
      .intr    (intr[i])
    );
  end

  always_comb begin
    rdMux = '0;
    if (addr == STAT_ADDR) begin
      for (int i = 0; i < NCH; i++) begin
        rdMux[2*i]   = buf_flag[i];
        rdMux[2*i+1] = intr[i];
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        if (addr == AW'(i)) rdMux = chRd[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      dout <= '0;
    else if (rdAcc) dout <= rdMux;
  end
endmodule

// File: doc/ppi_hs_ctrl.md
Name: ppi_hs_ctrl

Overview:
Clocked, parametrised successor to the 8255-style control logic. It has an 8-bit-compatible CPU register interface and NCH peripheral data channels. Each channel is independently configurable as basic I/O (mode 0) or strobed handshake I/O (mode 1), input or output, with per-channel interrupt enable and request. It sits between the CPU bus decode and the port pad drivers, and replaces the combinational enable generation with registered state.

Parameters:
DW, 8, data width of CPU bus and of each channel port (must be >= 8; control/status words use bits [7:0], upper bits written as ignored / read as 0)
NCH, 2, number of channels (1..4)
AW, 2, CPU address width; address 2^AW-1 = control, 2^AW-2 = status, 0..NCH-1 = channel data (requires NCH <= 2^AW-2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
cs_n  in  1  chip select, active low
rd_n  in  1  read strobe, active low
wr_n  in  1  write strobe, active low
addr  in  AW  register address
din  in  DW  CPU write data
dout  out  DW  CPU read data, registered
port_in  in  NCH*DW  peripheral input data, channel i at [i*DW +: DW]
port_out  out  NCH*DW  peripheral output data latches
port_oe  out  NCH  pad output enable per channel (1 = drive)
hs_n  in  NCH  peripheral handshake: STB_n in mode-1 input, ACK_n in mode-1 output
buf_flag  out  NCH  IBF (mode-1 input) or OBF (mode-1 output), active high
intr  out  NCH  interrupt request per channel

Behaviour:
- Reset (reset=1 at a rising edge) overrides all other activity. After it: all channels mode 0, direction input, port_oe=0, port_out=0, dout=0, buf_flag=0, intr_req=0, inte=0, internal edge-detect registers = 1.
- Access detection: rd_n and wr_n are registered each cycle (prev value). A write access occurs on the edge where cs_n=0, wr_n=0 and prev wr_n=1. A read access is defined the same way using rd_n. A long strobe therefore acts exactly once. If both accesses occur in the same cycle, the write is performed and the read is ignored.
- Control write (addr=2^AW-1), din[7]=1, mode set:
  - din[6:4] = channel index, din[1] = mode, din[0] = dir (1 = input).
  - Clears that channel's port_out, buf_flag, intr_req and inte.
  - port_oe[i] = ~dir from the next cycle.
- Control write, din[7]=0, INTE set/reset: din[6:4] = channel, inte[ch] = din[0].
- A channel index >= NCH is ignored.
- Data write (addr i < NCH): port_out[i] <= din.
  - Mode 1 output additionally sets buf_flag (OBF) and clears intr_req.
  - Writes to a channel configured as input are ignored.
  - Writes to the status address are ignored.
- Data read (addr i): dout <= port_in[i] sampled at that edge in mode 0 input; dout <= latched input register in mode 1 input; dout <= port_out[i] for output channels.
  - A mode-1 input read clears buf_flag (IBF) and intr_req.
- Status read: dout[2i+1:2i] = {intr[i], buf_flag[i]} for i < NCH; all other bits 0.
- Handshake edge detect: hs_d is the handshake sample (raw hs_n, or the synchronised value; see Optional Feature). A fall is hs_d=0 with previous=1; a rise is hs_d=1 with previous=0.
- Mode 1 input:
  - On a fall, latch port_in[i] (sampled that edge) and set IBF. A new strobe while IBF=1 overwrites the data.
  - On a rise with IBF=1, set intr_req.
- Mode 1 output:
  - On a fall, clear OBF.
  - On a rise with OBF=0, set intr_req.
- intr[i] = intr_req[i] & inte[i], both registered; clearing inte masks intr one cycle after the write edge.
- Simultaneous events in one cycle:
  - Strobe fall + CPU read clear: strobe wins, IBF=1, new data latched, intr_req cleared.
  - CPU write + ACK fall: write wins, OBF=1.
  - Mode-set + handshake on the same channel: mode-set wins.
- In mode 0, hs_n is ignored and buf_flag=0, intr=0.

Optional Feature:
PPI_HS_SYNC_EN:
- Defined: hs_n passes through a 2-flop synchroniser before edge detection. A fall/rise takes effect 3 rising edges after hs_n changes. The peripheral must hold port_in stable for >= 3 cycles after STB_n falls.
- Undefined: hs_n is registered once. Effect occurs at the 1st edge after the change, and port_in is sampled at that edge.

Test Plan:
- Reset, then read status -> dout=0x00, port_oe=0, intr=0, port_out=0.
- Mode-set ch0 mode 0 output (din=0x80), write addr0=0xA5 -> port_oe[0]=1 and port_out[7:0]=0xA5 the next cycle. Hold wr_n low 5 cycles with changing din -> only the first value is latched.
- Mode-set ch1 mode 1 input (0x93), INTE set (0x11). port_in ch1=0x3C, pulse hs_n[1] low 4 cycles -> IBF=1 after the fall (1 edge, or 3 with SYNC_EN). intr[1]=1 after the rise. Read addr1 -> dout=0x3C, IBF=0, intr=0.
- Ch0 mode 1 output (0x82), INTE on (0x01), write 0x5A -> OBF=1. Pulse ack low -> OBF=0 on the fall, intr[0]=1 on the rise. Next write clears intr.
- Same-cycle CPU read and STB fall on ch1 with new data 0x77 -> IBF stays 1 and the latch holds 0x77. A subsequent read returns 0x77.
- Assert reset mid-handshake with OBF=1, intr=1 -> next cycle all outputs are at reset values. Mode-set with index 5 (NCH=2) -> no state change.
